// File: rtl/gmii_pkg.sv
// Shared GMII MAC types and constants, used by the transmit framer and the
// receive-side FCS checker.
package gmii_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StPre,
      StSfd,
      StPayload,
      StPad,
      StFcs,
      StIfg
   } gmii_tx_state_t;

   localparam logic [7:0]  GMII_PREAMBLE = 8'h55;
   localparam logic [7:0]  GMII_SFD      = 8'hD5;
   localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;

endpackage

// File: rtl/gmii_mac_tx_if.sv
// Byte-stream source and GMII transmit signals of the MAC framer.
// master = packet source side, slave = framer side.
interface gmii_mac_tx_if;

   logic [7:0] in_dat;
   logic       in_val;
   logic       in_last;
   logic       in_rdy;
   logic [7:0] gmii_tx_dat;
   logic       gmii_tx_val;
   logic       gmii_tx_err;

   modport master (
      output in_dat, in_val, in_last,
      input  in_rdy, gmii_tx_dat, gmii_tx_val, gmii_tx_err
   );

   modport slave (
      input  in_dat, in_val, in_last,
      output in_rdy, gmii_tx_dat, gmii_tx_val, gmii_tx_err
   );

endinterface

// File: rtl/crc32_byte.sv
// Combinational reflected CRC-32 update for one byte, LSB first.
// Shared by the transmit framer and the receive FCS checker.
module crc32_byte
   import gmii_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  dat,
   output logic [31:0] crc_out
);

   always_comb begin
      crc_out = crc_in ^ {24'h000000, dat};
      for (int i = 0; i < 8; i++) begin
         crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC32_POLY) : (crc_out >> 1);
      end
   end

endmodule

// File: rtl/gmii_mac_tx.sv
// GMII MAC transmit framer: preamble/SFD, zero padding, CRC-32 FCS, inter-frame gap
// and underrun abort. Optional saturating counters under GMII_MAC_TX_STATS_EN.
module gmii_mac_tx
   import gmii_pkg::*;
#(
   parameter int unsigned PREAMBLE_LEN = 7,
   parameter int unsigned MIN_PAYLOAD  = 60,
   parameter int unsigned IFG_LEN      = 12
) (
   input  logic         clk,
   input  logic         rst,
   gmii_mac_tx_if.slave bus,
   output logic         busy
`ifdef GMII_MAC_TX_STATS_EN
   ,
   output logic [31:0]  stat_frames,
   output logic [15:0]  stat_underruns
`endif
);

   localparam logic [7:0] PreLast = 8'(PREAMBLE_LEN - 1);
   localparam logic [7:0] IfgLast = 8'(IFG_LEN - 1);

   gmii_tx_state_t state_q, state_d;
   logic [7:0]     ph_q, ph_d;
   logic [10:0]    cnt_q, cnt_d;
   logic [31:0]    crc_q, crc_d;
   logic [7:0]     dat_q, dat_d;
   logic           val_q, val_d;
   logic           err_q, err_d;

   logic [7:0]     crc_byte_in;
   logic [31:0]    crc_nxt;
   logic [31:0]    fcs;
   logic [7:0]     fcs_byte;
   logic [11:0]    cnt_inc;
   logic [10:0]    cnt_sat;
   logic           min_reached;

   assign crc_byte_in = (state_q == StPad) ? 8'h00 : bus.in_dat;

   crc32_byte u_crc (
      .crc_in  (crc_q),
      .dat     (crc_byte_in),
      .crc_out (crc_nxt)
   );

   assign fcs         = ~crc_q;
   assign fcs_byte    = fcs[{ph_q[1:0], 3'b000} +: 8];
   assign cnt_inc     = {1'b0, cnt_q} + 12'd1;
   assign cnt_sat     = (cnt_q == 11'h7FF) ? cnt_q : cnt_inc[10:0];
   assign min_reached = cnt_inc >= 12'(MIN_PAYLOAD);

   // Outputs are loaded together with the transition, so the IDLE cycle that
   // sees in_val already emits the first preamble byte.
   always_comb begin
      state_d = state_q;
      ph_d    = ph_q;
      cnt_d   = cnt_q;
      crc_d   = crc_q;
      dat_d   = 8'h00;
      val_d   = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.in_val) begin
               val_d   = 1'b1;
               dat_d   = GMII_PREAMBLE;
               ph_d    = 8'd1;
               state_d = (PREAMBLE_LEN > 1) ? StPre : StSfd;
            end
         end
         StPre: begin
            val_d = 1'b1;
            dat_d = GMII_PREAMBLE;
            if (ph_q == PreLast) state_d = StSfd;
            else                 ph_d    = ph_q + 8'd1;
         end
         StSfd: begin
            val_d   = 1'b1;
            dat_d   = GMII_SFD;
            crc_d   = CRC32_INIT;
            cnt_d   = 11'd0;
            state_d = StPayload;
         end
         StPayload: begin
            val_d = 1'b1;
            ph_d  = 8'd0;
            if (bus.in_val) begin
               dat_d = bus.in_dat;
               crc_d = crc_nxt;
               cnt_d = cnt_sat;
               if (bus.in_last) state_d = min_reached ? StFcs : StPad;
            end else begin
               err_d   = 1'b1;
               state_d = StIfg;
            end
         end
         StPad: begin
            val_d = 1'b1;
            crc_d = crc_nxt;
            cnt_d = cnt_sat;
            ph_d  = 8'd0;
            if (min_reached) state_d = StFcs;
         end
         StFcs: begin
            val_d = 1'b1;
            dat_d = fcs_byte;
            if (ph_q == 8'd3) begin
               ph_d    = 8'd0;
               state_d = StIfg;
            end else begin
               ph_d = ph_q + 8'd1;
            end
         end
         StIfg: begin
            if (ph_q == IfgLast) state_d = StIdle;
            else                 ph_d    = ph_q + 8'd1;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         ph_q    <= 8'd0;
         cnt_q   <= 11'd0;
         crc_q   <= CRC32_INIT;
         dat_q   <= 8'h00;
         val_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ph_q    <= ph_d;
         cnt_q   <= cnt_d;
         crc_q   <= crc_d;
         dat_q   <= dat_d;
         val_q   <= val_d;
         err_q   <= err_d;
      end
   end

   assign bus.in_rdy      = (state_q == StPayload);
   assign bus.gmii_tx_dat = dat_q;
   assign bus.gmii_tx_val = val_q;
   assign bus.gmii_tx_err = err_q;
   assign busy            = (state_q != StIdle);

`ifdef GMII_MAC_TX_STATS_EN
   logic [31:0] frames_q;
   logic [15:0] underruns_q;
   logic        frame_done;
   logic        underrun;

   assign frame_done = (state_q == StFcs) && (ph_q == 8'd3);
   assign underrun   = (state_q == StPayload) && !bus.in_val;

   always_ff @(posedge clk) begin
      if (rst) begin
         frames_q    <= 32'd0;
         underruns_q <= 16'd0;
      end else begin
         if (frame_done && (frames_q != 32'hFFFFFFFF)) frames_q <= frames_q + 32'd1;
         if (underrun && (underruns_q != 16'hFFFF))    underruns_q <= underruns_q + 16'd1;
      end
   end

   assign stat_frames    = frames_q;
   assign stat_underruns = underruns_q;
`endif

endmodule

// File: tb/tb_gmii_mac_tx.sv
// Randomized bench for gmii_mac_tx: a queue-based frame model predicts every output cycle
// of two instances (MIN_PAYLOAD=0 and defaults); literal checks pin the model.
module tb_gmii_mac_tx;

   localparam int PRE = 7;
   localparam int IFG = 12;

   typedef logic [7:0] bq_t [$];
   typedef struct packed {
      logic       val;
      logic       err;
      logic [7:0] dat;
      logic       busy;
      logic       rdy;
   } ent_t;

   logic clk = 1'b0;
   logic rst;
   always #4 clk = ~clk;

   int checks = 0;
   int errors = 0;

   gmii_mac_tx_if if_a ();
   gmii_mac_tx_if if_b ();

   logic [7:0] s_dat  [2];
   logic       s_val  [2];
   logic       s_last [2];
   logic [7:0] o_dat  [2];
   logic       o_val  [2];
   logic       o_err  [2];
   logic       o_rdy  [2];
   logic       o_busy [2];

   assign if_a.in_dat  = s_dat[0];
   assign if_a.in_val  = s_val[0];
   assign if_a.in_last = s_last[0];
   assign if_b.in_dat  = s_dat[1];
   assign if_b.in_val  = s_val[1];
   assign if_b.in_last = s_last[1];
   assign o_dat[0] = if_a.gmii_tx_dat;
   assign o_val[0] = if_a.gmii_tx_val;
   assign o_err[0] = if_a.gmii_tx_err;
   assign o_rdy[0] = if_a.in_rdy;
   assign o_dat[1] = if_b.gmii_tx_dat;
   assign o_val[1] = if_b.gmii_tx_val;
   assign o_err[1] = if_b.gmii_tx_err;
   assign o_rdy[1] = if_b.in_rdy;

`ifdef GMII_MAC_TX_STATS_EN
   logic [31:0] sf [2];
   logic [15:0] su [2];
`endif

   gmii_mac_tx #(.PREAMBLE_LEN(PRE), .MIN_PAYLOAD(0), .IFG_LEN(IFG)) dut_a (
      .clk  (clk),
      .rst  (rst),
      .bus  (if_a),
      .busy (o_busy[0])
`ifdef GMII_MAC_TX_STATS_EN
      ,
      .stat_frames    (sf[0]),
      .stat_underruns (su[0])
`endif
   );

   gmii_mac_tx dut_b (
      .clk  (clk),
      .rst  (rst),
      .bus  (if_b),
      .busy (o_busy[1])
`ifdef GMII_MAC_TX_STATS_EN
      ,
      .stat_frames    (sf[1]),
      .stat_underruns (su[1])
`endif
   );

   // Model state: expected per-cycle output stream and observed-stream statistics.
   ent_t       expq [2][$];
   logic [7:0] cap  [2][$];
   int         vcnt [2];
   int         errcnt [2];
   int         idle_run [2];
   int         gap_last [2];
   bit         seen_val [2];
   int         mdl_frames [2];
   int         mdl_unders [2];
   bit         chk_en = 1'b0;

   function automatic int minp(input int d);
      return (d == 0) ? 0 : 60;
   endfunction

   function automatic ent_t ent(input logic v, input logic e, input logic [7:0] dt,
                                input logic b, input logic r);
      return {v, e, dt, b, r};
   endfunction

   function automatic logic [31:0] crc32(input bq_t b);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (b[i]) begin
         c = c ^ {24'h0, b[i]};
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return ~c;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, got, want);
      end
   endtask

   task automatic push_frame(input int d, input bq_t pl, input int abort_at, input bit lead);
      int          n;
      bq_t         body;
      logic [31:0] fcs;
      n = pl.size();
      if (lead) expq[d].push_back(ent(0, 0, 8'h00, 0, 0));
      for (int i = 0; i < PRE; i++) expq[d].push_back(ent(1, 0, 8'h55, 1, 0));
      expq[d].push_back(ent(1, 0, 8'hD5, 1, 1));
      if (abort_at >= 1 && abort_at < n) begin
         for (int i = 0; i < abort_at; i++) expq[d].push_back(ent(1, 0, pl[i], 1, 1));
         expq[d].push_back(ent(1, 1, 8'h00, 1, 0));
         mdl_unders[d]++;
      end else begin
         body = pl;
         while (body.size() < minp(d)) body.push_back(8'h00);
         for (int i = 0; i < n; i++) expq[d].push_back(ent(1, 0, pl[i], 1, i < n - 1));
         for (int i = n; i < body.size(); i++) expq[d].push_back(ent(1, 0, 8'h00, 1, 0));
         fcs = crc32(body);
         for (int k = 0; k < 4; k++) expq[d].push_back(ent(1, 0, fcs[8*k +: 8], 1, 0));
         mdl_frames[d]++;
      end
      for (int i = 0; i < IFG; i++) expq[d].push_back(ent(0, 0, 8'h00, i < IFG - 1, 0));
   endtask

   task automatic drive(input int d, input bq_t pl, input int abort_at);
      bit acc;
      int guard;
      for (int i = 0; i < pl.size(); i++) begin
         if (i == abort_at) begin
            s_val[d]  = 1'b0;
            s_last[d] = 1'b0;
            return;
         end
         s_dat[d]  = pl[i];
         s_last[d] = (i == pl.size() - 1);
         s_val[d]  = 1'b1;
         acc   = 1'b0;
         guard = 0;
         while (!acc) begin
            acc = o_rdy[d];
            @(posedge clk);
            #1;
            guard++;
            if (guard > 400) begin
               chk("accept_timeout", 32'(guard), 32'd400);
               s_val[d] = 1'b0;
               return;
            end
         end
      end
      s_val[d]  = 1'b0;
      s_last[d] = 1'b0;
   endtask

   task automatic wait_drain(input int d);
      int g;
      g = 0;
      while (expq[d].size() != 0) begin
         @(posedge clk);
         #1;
         g++;
         if (g > 5000) begin
            chk("drain_timeout", 32'(expq[d].size()), 32'd0);
            expq[d].delete();
         end
      end
   endtask

   task automatic run_frame(input int d, input bq_t pl, input int abort_at, input bit b2b);
      if (!b2b) wait_drain(d);
      push_frame(d, pl, abort_at, !b2b);
      drive(d, pl, abort_at);
   endtask

   function automatic bq_t rand_bytes(input int n);
      bq_t q;
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      return q;
   endfunction

   task automatic clear_obs(input int d);
      vcnt[d]   = 0;
      errcnt[d] = 0;
      cap[d].delete();
   endtask

   ent_t ce, ca;
   always @(negedge clk) begin
      if (chk_en) begin
         for (int d = 0; d < 2; d++) begin
            ce = '0;
            if (expq[d].size() > 0) ce = expq[d].pop_front();
            ca = {o_val[d], o_err[d], (o_val[d] ? o_dat[d] : 8'h00), o_busy[d], o_rdy[d]};
            checks++;
            if (ca !== ce) begin
               errors++;
               $display("FAIL stream dut%0d t=%0t got v%0b e%0b d%02h b%0b r%0b want v%0b e%0b d%02h b%0b r%0b",
                        d, $time, ca.val, ca.err, ca.dat, ca.busy, ca.rdy,
                        ce.val, ce.err, ce.dat, ce.busy, ce.rdy);
            end
            if (o_val[d]) begin
               vcnt[d]++;
               cap[d].push_back(o_dat[d]);
               if (o_err[d]) errcnt[d]++;
               if (seen_val[d] && idle_run[d] > 0) gap_last[d] = idle_run[d];
               seen_val[d] = 1'b1;
               idle_run[d] = 0;
            end else begin
               idle_run[d]++;
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      bq_t   pl, p2;
      string s;
      int    g, nz, d, prev_d, len, ab;
      bit    prev_ok, b2b;

      for (int i = 0; i < 2; i++) begin
         s_dat[i] = 8'h00; s_val[i] = 1'b0; s_last[i] = 1'b0;
         vcnt[i] = 0; errcnt[i] = 0; idle_run[i] = 0; gap_last[i] = 0; seen_val[i] = 1'b0;
         mdl_frames[i] = 0; mdl_unders[i] = 0;
      end
      rst = 1'b1;
      s_val[1] = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++)
         chk($sformatf("reset_state%0d", i), {27'h0, o_val[i], o_err[i], o_busy[i], o_rdy[i],
             |o_dat[i]}, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      s_val[1] = 1'b0;
      chk_en = 1'b1;

      // Check value of CRC-32 pins the reference model.
      s = "123456789";
      pl.delete();
      for (int i = 0; i < s.len(); i++) pl.push_back(s[i]);
      chk("crc_model_check", crc32(pl), 32'hCBF43926);

      // Unpadded frame on the MIN_PAYLOAD=0 instance.
      clear_obs(0);
      run_frame(0, pl, -1, 1'b0);
      wait_drain(0);
      chk("t1_val_cycles", 32'(vcnt[0]), 32'd21);
      chk("t1_pre0", 32'(cap[0][0]), 32'h55);
      chk("t1_sfd", 32'(cap[0][7]), 32'hD5);
      chk("t1_first_payload", 32'(cap[0][8]), 32'h31);
      chk("t1_fcs", {cap[0][20], cap[0][19], cap[0][18], cap[0][17]}, 32'hCBF43926);
      chk("t1_err", 32'(errcnt[0]), 32'd0);

      // Short payload padded to 60 bytes.
      clear_obs(1);
      run_frame(1, rand_bytes(14), -1, 1'b0);
      wait_drain(1);
      chk("t2_val_cycles", 32'(vcnt[1]), 32'd72);
      nz = 0;
      for (int i = 22; i < 68; i++) if (cap[1][i] == 8'h00) nz++;
      chk("t2_pad_zeros", 32'(nz), 32'd46);

      // Back-to-back 64-byte frames.
      clear_obs(1);
      run_frame(1, rand_bytes(64), -1, 1'b0);
      run_frame(1, rand_bytes(64), -1, 1'b1);
      wait_drain(1);
      chk("t3_val_cycles", 32'(vcnt[1]), 32'd152);
      chk("t3_ifg_gap", 32'(gap_last[1]), 32'd12);

      // Underrun after 20 of 64 bytes.
      clear_obs(1);
      run_frame(1, rand_bytes(64), 20, 1'b0);
      wait_drain(1);
      chk("t4_err_cycles", 32'(errcnt[1]), 32'd1);
      chk("t4_val_cycles", 32'(vcnt[1]), 32'd29);
`ifdef GMII_MAC_TX_STATS_EN
      chk("t4_stat_underruns", 32'(su[1]), 32'd1);
      chk("t4_stat_frames", sf[1], 32'd3);
`endif

      // Reset during the third FCS byte, then a clean frame.
      run_frame(1, rand_bytes(64), -1, 1'b0);
      g = 0;
      while (expq[1].size() != IFG + 2 && g < 500) begin
         @(posedge clk);
         #1;
         g++;
      end
      chk("t5_reach_fcs2", 32'(expq[1].size()), 32'(IFG + 2));
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      expq[1].delete();
      for (int i = 0; i < 2; i++) begin
         mdl_frames[i] = 0;
         mdl_unders[i] = 0;
      end
      @(negedge clk);
      chk("t5_val_after_rst", 32'(o_val[1]), 32'd0);
      chk("t5_busy_after_rst", 32'(o_busy[1]), 32'd0);
      @(posedge clk);
      #1;
      clear_obs(1);
      run_frame(1, rand_bytes(64), -1, 1'b0);
      wait_drain(1);
      nz = 0;
      for (int i = 0; i < 7; i++) if (cap[1][i] == 8'h55) nz++;
      chk("t5_full_preamble", 32'(nz), 32'd7);
      chk("t5_val_cycles", 32'(vcnt[1]), 32'd76);

      // Payload longer than the saturating byte counter.
      clear_obs(1);
      run_frame(1, rand_bytes(2100), -1, 1'b0);
      wait_drain(1);
      chk("t6_val_cycles", 32'(vcnt[1]), 32'd2112);

      // Randomized mix of lengths, aborts and back-to-back starts on both instances.
      prev_ok = 1'b0;
      prev_d  = 0;
      for (int f = 0; f < 30; f++) begin
         d   = int'($urandom_range(0, 1));
         len = int'($urandom_range(1, 120));
         ab  = -1;
         if (len > 1 && $urandom_range(0, 3) == 0) ab = int'($urandom_range(1, len - 1));
         b2b = prev_ok && (prev_d == d) && ($urandom_range(0, 1) == 1);
         if (!b2b) begin
            wait_drain(0);
            wait_drain(1);
            repeat ($urandom_range(0, 5)) begin
               @(posedge clk);
               #1;
            end
         end
         p2 = rand_bytes(len);
         run_frame(d, p2, ab, b2b);
         prev_ok = (ab < 0);
         prev_d  = d;
      end
      wait_drain(0);
      wait_drain(1);
`ifdef GMII_MAC_TX_STATS_EN
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("stat_frames%0d", i), sf[i], 32'(mdl_frames[i]));
         chk($sformatf("stat_underruns%0d", i), 32'(su[i]), 32'(mdl_unders[i]));
      end
`endif
      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
